byte_loopback_buffer: RTL and testbench

- Parametrised staging buffer between the single-byte receive path (active_transfer) and the block transmit path (active_block).
- Collects a host-selected number of received bytes into on-chip memory, then requests a block transfer and serves the bytes back in order.
- Fully synchronous to uc_clk: strobes are edge-detected inside the block, not used as clocks.
- Optional trailing checksum byte.

---
 rtl/byte_loopback_buffer.sv | 222 ++++++++++++++++++++++
 tb/tb_byte_loopback_buffer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_loopback_buffer.sv
// ---------------------------------------------------------------------------
// byte_loopback_buffer
//
// Staging buffer between the single-byte receive path (active_transfer) and
// the block transmit path (active_block). A fill of L bytes is collected into
// on-chip memory. The block is then announced to the transmitter with
// tx_start/tx_len, and the bytes are served back in order, one per rising
// edge of tx_ready. Everything runs on uc_clk. The strobes are edge-detected
// here and are never used as clocks.
//
// Optional feature (macro BYTE_LOOPBACK_CHKSUM_EN): a trailing byte is
// appended to every block. It holds the mod-256 sum of the filled bytes.
//
// Parameters
//   DEPTH       buffer capacity in bytes (1..254)
//   CNT_W       width of counters and fill_count
//
// Ports
//   uc_clk      system clock
//   uc_reset    synchronous active-high reset
//   flush       synchronous clear of buffer and flags (keeps tx_byte, last_byte)
//   block_len   requested block length, sampled on the first byte of a fill
//   rx_strobe   byte-received level from active_transfer
//   rx_byte     received byte
//   tx_start    block transfer request to active_block
//   tx_ready    byte-taken level from active_block
//   tx_byte     byte currently offered to the host
//   tx_len      block length presented to active_block
//   fill_count  bytes currently stored
//   last_byte   most recently accepted rx byte
//   busy        high while loading or draining a block
//   done        one-cycle pulse at block completion
//   overflow    sticky flag: a received byte was dropped
// ---------------------------------------------------------------------------
module byte_loopback_buffer #(
   parameter int DEPTH = 36,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             uc_clk,
   input  logic             uc_reset,
   input  logic             flush,
   input  logic [7:0]       block_len,
   input  logic             rx_strobe,
   input  logic [7:0]       rx_byte,
   output logic             tx_start,
   input  logic             tx_ready,
   output logic [7:0]       tx_byte,
   output logic [7:0]       tx_len,
   output logic [CNT_W-1:0] fill_count,
   output logic [7:0]       last_byte,
   output logic             busy,
   output logic             done,
   output logic             overflow
);

   localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [7:0]       DEPTH_B = 8'(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {S_FILL, S_LOAD, S_DRAIN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic             rx_strobe_q, tx_ready_q;
   logic             rx_evt, rdy_evt;
   logic [7:0]       mem [DEPTH];
   // fill_q doubles as the write pointer: it always equals the next free slot.
   logic [CNT_W-1:0] fill_q, rd_ptr_q, len_q;
   logic [CNT_W-1:0] l_eff, len_cur, fill_inc;
   logic [CNT_W:0]   cons_q, cons_inc, cons_total;
   logic             tx_start_q, overflow_q;
   logic [7:0]       tx_byte_q, tx_len_q, last_byte_q, tx_len_new;
   logic             wr_en, last_wr, drain_end;
`ifdef BYTE_LOOPBACK_CHKSUM_EN
   logic [7:0]       sum_q;
`endif

   assign rx_evt  = rx_strobe & ~rx_strobe_q;
   assign rdy_evt = tx_ready & ~tx_ready_q;

   // Out-of-range requests (0 or larger than the buffer) fall back to DEPTH.
   assign l_eff   = (block_len != 8'd0 && block_len <= DEPTH_B) ? CNT_W'(block_len) : DEPTH_C;
   // The length is latched on the first byte, but that same byte must already
   // be compared against it (L == 1 completes on the first write).
   assign len_cur  = (fill_q == '0) ? l_eff : len_q;
   assign fill_inc = fill_q + CNT_W'(1);
   assign wr_en    = (state_q == S_FILL) && rx_evt;
   assign last_wr  = wr_en && (fill_inc == len_cur);

   assign cons_inc = cons_q + (CNT_W+1)'(1);
`ifdef BYTE_LOOPBACK_CHKSUM_EN
   assign cons_total = {1'b0, len_q} + (CNT_W+1)'(1);
   assign tx_len_new = 8'(len_q) + 8'd1;
`else
   assign cons_total = {1'b0, len_q};
   assign tx_len_new = 8'(len_q);
`endif
   assign drain_end = (state_q == S_DRAIN) && rdy_evt && (cons_inc == cons_total);

   // State register
   always_ff @(posedge uc_clk) begin
      if (uc_reset) state_q <= S_FILL;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FILL:  if (last_wr) state_d = S_LOAD;
         S_LOAD:  state_d = S_DRAIN;
         S_DRAIN: if (drain_end) state_d = S_DONE;
         S_DONE:  state_d = S_FILL;
      endcase
      if (flush) state_d = S_FILL;
   end

   // Output decode
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         S_LOAD, S_DRAIN: busy = 1'b1;
         S_DONE:          done = 1'b1;
         default:         ;
      endcase
   end

   // Byte storage: no reset, contents are only meaningful below fill_q.
   always_ff @(posedge uc_clk) begin
      if (wr_en && !uc_reset && !flush) mem[fill_q[IDX_W-1:0]] <= rx_byte;
   end

   // Datapath and flags
   always_ff @(posedge uc_clk) begin
      if (uc_reset) begin
         rx_strobe_q <= 1'b0;
         tx_ready_q  <= 1'b0;
         fill_q      <= '0;
         rd_ptr_q    <= '0;
         len_q       <= '0;
         cons_q      <= '0;
         tx_start_q  <= 1'b0;
         tx_len_q    <= 8'd0;
         overflow_q  <= 1'b0;
         tx_byte_q   <= 8'd0;
         last_byte_q <= 8'd0;
`ifdef BYTE_LOOPBACK_CHKSUM_EN
         sum_q       <= 8'd0;
`endif
      end else if (flush) begin
         // Abandons any block in flight; a coincident strobe edge is discarded
         // silently. tx_byte and last_byte keep their values.
         rx_strobe_q <= 1'b0;
         tx_ready_q  <= 1'b0;
         fill_q      <= '0;
         rd_ptr_q    <= '0;
         len_q       <= '0;
         cons_q      <= '0;
         tx_start_q  <= 1'b0;
         tx_len_q    <= 8'd0;
         overflow_q  <= 1'b0;
`ifdef BYTE_LOOPBACK_CHKSUM_EN
         sum_q       <= 8'd0;
`endif
      end else begin
         rx_strobe_q <= rx_strobe;
         tx_ready_q  <= tx_ready;
         case (state_q)
            S_FILL: begin
               if (rx_evt) begin
                  if (fill_q == '0) len_q <= l_eff;
                  fill_q      <= fill_inc;
                  last_byte_q <= rx_byte;
`ifdef BYTE_LOOPBACK_CHKSUM_EN
                  sum_q       <= sum_q + rx_byte;
`endif
               end
            end
            S_LOAD: begin
               tx_byte_q  <= mem[0];
               rd_ptr_q   <= CNT_W'(1);
               tx_len_q   <= tx_len_new;
               tx_start_q <= 1'b1;
               cons_q     <= '0;
            end
            S_DRAIN: begin
               if (rdy_evt) begin
                  cons_q <= cons_inc;
                  if (cons_inc < {1'b0, len_q}) begin
                     tx_byte_q <= mem[rd_ptr_q[IDX_W-1:0]];
                     rd_ptr_q  <= rd_ptr_q + CNT_W'(1);
                  end
`ifdef BYTE_LOOPBACK_CHKSUM_EN
                  else if (cons_inc == {1'b0, len_q}) begin
                     tx_byte_q <= sum_q;
                  end
`endif
               end
            end
            S_DONE: begin
               tx_start_q <= 1'b0;
               fill_q     <= '0;
               rd_ptr_q   <= '0;
               cons_q     <= '0;
`ifdef BYTE_LOOPBACK_CHKSUM_EN
               sum_q      <= 8'd0;
`endif
            end
         endcase
         // Bytes arriving while a block is out cannot be stored.
         if (rx_evt && state_q != S_FILL) overflow_q <= 1'b1;
      end
   end

   assign tx_start   = tx_start_q;
   assign tx_byte    = tx_byte_q;
   assign tx_len     = tx_len_q;
   assign fill_count = fill_q;
   assign last_byte  = last_byte_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_byte_loopback_buffer.sv
module tb_byte_loopback_buffer;

   localparam int DEPTH = 36;
   localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef BYTE_LOOPBACK_CHKSUM_EN
   localparam int CHK = 1;
`else
   localparam int CHK = 0;
`endif

   logic             uc_clk;
   logic             uc_reset;
   logic             flush;
   logic [7:0]       block_len;
   logic             rx_strobe;
   logic [7:0]       rx_byte;
   logic             tx_start;
   logic             tx_ready;
   logic [7:0]       tx_byte;
   logic [7:0]       tx_len;
   logic [CNT_W-1:0] fill_count;
   logic [7:0]       last_byte;
   logic             busy;
   logic             done;
   logic             overflow;

   byte_loopback_buffer #(.DEPTH(DEPTH)) dut (
      .uc_clk     (uc_clk),
      .uc_reset   (uc_reset),
      .flush      (flush),
      .block_len  (block_len),
      .rx_strobe  (rx_strobe),
      .rx_byte    (rx_byte),
      .tx_start   (tx_start),
      .tx_ready   (tx_ready),
      .tx_byte    (tx_byte),
      .tx_len     (tx_len),
      .fill_count (fill_count),
      .last_byte  (last_byte),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow)
   );

   initial uc_clk = 1'b0;
   always #5 uc_clk = ~uc_clk;

   int         errs   = 0;
   int         checks = 0;
   logic [7:0] sb[$];          // bytes the DUT must serve, in order
   logic [7:0] sum_m  = 8'd0;  // model of the trailing checksum
   logic [7:0] last_m = 8'd0;  // model of last_byte

   task automatic tick();
      @(posedge uc_clk);
      #1;
   endtask

   function automatic int eff_len(input int b);
      return (b >= 1 && b <= DEPTH) ? b : DEPTH;
   endfunction

   // One-cycle strobe followed by one idle cycle so the next byte is a new edge.
   task automatic send_byte(input logic [7:0] b, input bit accept);
      rx_byte   = b;
      rx_strobe = 1'b1;
      tick();
      rx_strobe = 1'b0;
      if (accept) begin
         sb.push_back(b);
         sum_m  = sum_m + b;
         last_m = b;
      end
      tick();
   endtask

   task automatic close_fill();
      if (CHK != 0) sb.push_back(sum_m);
      sum_m = 8'd0;
   endtask

   task automatic fill_rand(input int blen, input int n);
      block_len = 8'(blen);
      for (int k = 0; k < n; k++) send_byte(8'($urandom), 1'b1);
   endtask

   task automatic check_drain_start(input int l);
      checks++; if (tx_start !== 1'b1) begin errs++; $display("FAIL start_tx_start: got %b want 1", tx_start); end
      checks++; if (busy !== 1'b1) begin errs++; $display("FAIL start_busy: got %b want 1", busy); end
      checks++; if (tx_len !== 8'(l + CHK)) begin errs++; $display("FAIL start_tx_len: got %0d want %0d", tx_len, l + CHK); end
      checks++;
      if (sb.size() == 0 || tx_byte !== sb[0]) begin
         errs++; $display("FAIL start_tx_byte: got %h want %h", tx_byte, (sb.size() != 0) ? sb[0] : 8'hxx);
      end
   endtask

   // Serves every scoreboard entry with ready pulses of the given width.
   task automatic drain_block(input int width);
      int total = sb.size();
      int dones = 0;
      logic [7:0] exp_b;
      for (int k = 0; k < total; k++) begin
         exp_b = sb.pop_front();
         checks++; if (tx_byte !== exp_b) begin errs++; $display("FAIL drain_byte[%0d]: got %h want %h", k, tx_byte, exp_b); end
         tx_ready = 1'b1;
         for (int c = 0; c < width; c++) begin
            tick();
            if (done === 1'b1) dones++;
            if (k == total - 1 && c == 0) begin
               checks++; if (done !== 1'b1) begin errs++; $display("FAIL done_timing: got %b want 1", done); end
            end
         end
         tx_ready = 1'b0;
         tick();
         if (done === 1'b1) dones++;
      end
      checks++; if (dones != 1) begin errs++; $display("FAIL done_count: got %0d want 1", dones); end
      checks++; if (tx_start !== 1'b0) begin errs++; $display("FAIL end_tx_start: got %b want 0", tx_start); end
      checks++; if (fill_count !== '0) begin errs++; $display("FAIL end_fill: got %0d want 0", fill_count); end
      checks++; if (busy !== 1'b0) begin errs++; $display("FAIL end_busy: got %b want 0", busy); end
   endtask

   task automatic check_reset_values(input string tag);
      checks++; if (tx_start !== 1'b0) begin errs++; $display("FAIL %s_tx_start: got %b want 0", tag, tx_start); end
      checks++; if (tx_byte !== 8'd0) begin errs++; $display("FAIL %s_tx_byte: got %h want 00", tag, tx_byte); end
      checks++; if (tx_len !== 8'd0) begin errs++; $display("FAIL %s_tx_len: got %h want 00", tag, tx_len); end
      checks++; if (fill_count !== '0) begin errs++; $display("FAIL %s_fill: got %0d want 0", tag, fill_count); end
      checks++; if (last_byte !== 8'd0) begin errs++; $display("FAIL %s_last_byte: got %h want 00", tag, last_byte); end
      checks++; if (busy !== 1'b0) begin errs++; $display("FAIL %s_busy: got %b want 0", tag, busy); end
      checks++; if (done !== 1'b0) begin errs++; $display("FAIL %s_done: got %b want 0", tag, done); end
      checks++; if (overflow !== 1'b0) begin errs++; $display("FAIL %s_overflow: got %b want 0", tag, overflow); end
   endtask

   task automatic test_reset();
      uc_reset = 1'b1;
      repeat (2) tick();
      uc_reset = 1'b0;
      check_reset_values("reset");
   endtask

   task automatic test_fill();
      block_len = 8'd4;
      for (int k = 0; k < 3; k++) begin
         send_byte(8'((k + 1) * 17), 1'b1);
         checks++; if (fill_count !== CNT_W'(k + 1)) begin errs++; $display("FAIL fill_count[%0d]: got %0d want %0d", k, fill_count, k + 1); end
      end
      rx_byte = 8'h44; rx_strobe = 1'b1;
      tick();
      rx_strobe = 1'b0;
      sb.push_back(8'h44); sum_m = sum_m + 8'h44; last_m = 8'h44;
      checks++; if (fill_count !== CNT_W'(4)) begin errs++; $display("FAIL fill_count[3]: got %0d want 4", fill_count); end
      checks++; if (last_byte !== 8'h44) begin errs++; $display("FAIL fill_last_byte: got %h want 44", last_byte); end
      checks++; if (busy !== 1'b1 || tx_start !== 1'b0) begin errs++; $display("FAIL load_state: got busy=%b tx_start=%b want busy=1 tx_start=0", busy, tx_start); end
      tick();
      close_fill();
      check_drain_start(4);
   endtask

   task automatic test_drain();
      drain_block(3);
   endtask

   task automatic test_len_clamp();
      int lens[3] = '{0, 200, 1};
      foreach (lens[i]) begin
         int l = eff_len(lens[i]);
         fill_rand(lens[i], l - 1);
         checks++; if (busy !== 1'b0 || fill_count !== CNT_W'(l - 1)) begin errs++; $display("FAIL clamp_prefill[%0d]: got busy=%b fill=%0d want busy=0 fill=%0d", lens[i], busy, fill_count, l - 1); end
         send_byte(8'($urandom), 1'b1);
         close_fill();
         check_drain_start(l);
         drain_block(1);
      end
   endtask

   task automatic test_overflow();
      // A ready edge while filling must be ignored.
      tx_ready = 1'b1; tick(); tx_ready = 1'b0; tick();
      fill_rand(3, 3);
      close_fill();
      check_drain_start(3);
      send_byte(8'h55, 1'b0);
      checks++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_set: got %b want 1", overflow); end
      checks++; if (last_byte !== last_m) begin errs++; $display("FAIL ovf_last_byte: got %h want %h", last_byte, last_m); end
      drain_block(2);
      checks++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
      flush = 1'b1; tick(); flush = 1'b0;
      checks++; if (overflow !== 1'b0) begin errs++; $display("FAIL ovf_flush: got %b want 0", overflow); end
      checks++; if (last_byte !== last_m) begin errs++; $display("FAIL flush_keeps_last: got %h want %h", last_byte, last_m); end
   endtask

   task automatic test_simultaneous();
      logic [7:0] held;
      block_len = 8'd4;
      send_byte(8'hA1, 1'b1);
      send_byte(8'hA2, 1'b1);
      rx_byte = 8'hA3; rx_strobe = 1'b1; flush = 1'b1;
      tick();
      rx_strobe = 1'b0; flush = 1'b0;
      sb.delete(); sum_m = 8'd0;
      checks++; if (fill_count !== '0) begin errs++; $display("FAIL sim_flush_fill: got %0d want 0", fill_count); end
      checks++; if (overflow !== 1'b0) begin errs++; $display("FAIL sim_flush_ovf: got %b want 0", overflow); end
      checks++; if (last_byte !== 8'hA2) begin errs++; $display("FAIL sim_flush_last: got %h want a2", last_byte); end
      tick();
      // Flush in the middle of a drain abandons the block.
      fill_rand(2, 2);
      close_fill();
      check_drain_start(2);
      held = sb[0];
      flush = 1'b1; tick(); flush = 1'b0;
      sb.delete();
      checks++; if (tx_start !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL drain_flush: got tx_start=%b busy=%b want 0 0", tx_start, busy); end
      checks++; if (tx_byte !== held) begin errs++; $display("FAIL drain_flush_tx_byte: got %h want %h", tx_byte, held); end
      // Reset in the middle of a drain.
      fill_rand(2, 2);
      close_fill();
      check_drain_start(2);
      uc_reset = 1'b1; tick(); uc_reset = 1'b0;
      sb.delete(); last_m = 8'd0;
      check_reset_values("drain_reset");
      // A normal block must still work afterwards.
      fill_rand(5, 5);
      close_fill();
      check_drain_start(5);
      drain_block(2);
   endtask

`ifdef BYTE_LOOPBACK_CHKSUM_EN
   task automatic test_chksum();
      block_len = 8'd3;
      send_byte(8'hF0, 1'b1);
      send_byte(8'h20, 1'b1);
      send_byte(8'h05, 1'b1);
      close_fill();
      check_drain_start(3);
      drain_block(2);
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      uc_reset  = 1'b0;
      flush     = 1'b0;
      block_len = 8'd0;
      rx_strobe = 1'b0;
      rx_byte   = 8'd0;
      tx_ready  = 1'b0;
      test_reset();
      test_fill();
      test_drain();
      test_len_clamp();
      test_overflow();
      test_simultaneous();
`ifdef BYTE_LOOPBACK_CHKSUM_EN
      test_chksum();
`endif
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
